sub_64_seq: RTL and testbench
=============================

// Module: sub_64_seq
// PURPOSE
// - Multi-cycle 64-bit subtractor with borrow: D = A - B - borrow_in. This is the inverse operation of the 64-bit CLA adder.
// - Processes one CHUNK-bit slice per clock through a single combinational chunk adder, computed as A + ~B + ~borrow_in.
// - Operand and result transfer use valid/ready handshakes. Sits in the datapath beside the adder and is shared by ALU-level sequencing.
// PARAMETERS
// - W      64  operand/result width; must be a multiple of CHUNK
// - CHUNK  16  slice width per cycle; NCHUNK = W/CHUNK (default 4)
// PORTS
// - i_clk         in   1  clock, rising edge
// - i_rst_n       in   1  reset, asynchronous, active-low
// - i_valid       in   1  operands valid
// - o_ready       out  1  block can accept operands
// - i_a           in   W  minuend
// - i_b           in   W  subtrahend
// - i_borrow_in   in   1  incoming borrow
// - o_valid       out  1  result valid
// - i_ready       in   1  consumer accepts result
// - o_d           out  W  difference
// - o_borrow_out  out  1  1 iff A < B + borrow_in (unsigned)
// - o_overflow    out  1  signed overflow
// - o_zero        out  1  o_d == 0
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-low.
// - Reset values: state IDLE; o_ready=1; o_valid=0; o_d=0; o_borrow_out=0; o_overflow=0; o_zero=0; chunk index 0.
// - FSM IDLE -> RUN -> DONE -> IDLE.
// - IDLE: o_ready=1. When i_valid & o_ready:
//   - latch A, ~B, and carry = ~i_borrow_in;
//   - latch sign bits a[W-1] and b[W-1];
//   - go to RUN with idx=0.
// - RUN: o_ready=0. Each cycle:
//   - add slice idx of A, slice idx of ~B, and carry;
//   - write the sum slice into the result register;
//   - carry <= slice carry-out; idx++.
//   - After slice NCHUNK-1, go to DONE.
// - DONE: o_valid=1. Outputs are registered and held stable until i_ready:
//   - o_borrow_out = ~final_carry;
//   - o_overflow = (a_msb != b_msb) & (d_msb != a_msb);
//   - o_zero = (o_d == 0).
// - Leaving DONE: on i_valid & ... no; on o_valid & i_ready, go to IDLE and drop o_valid next cycle.
// - No same-cycle accept in DONE: o_ready is 0 outside IDLE.
// - Latency: accept at edge N gives o_valid=1 after edge N+NCHUNK (4 cycles by default). Throughput is one op per NCHUNK+2 cycles with no backpressure.
// - Inputs are ignored outside IDLE. Operands are sampled only at the accept edge, so later changes to i_a/i_b have no effect.
// - o_d holds its last value in IDLE and RUN until it is overwritten; it is meaningful only while o_valid=1.
// - Wrap-around: results are modulo 2^W. 0 - 1 gives all-ones with borrow 1.
// - Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The in-flight op is discarded with no partial o_valid.
// - i_ready held low in DONE: stay in DONE indefinitely, outputs unchanged.
// - X-free: all state registers are reset; no output depends on unsampled inputs.
// STRUCTURE
// - Package sub_64_pkg:
//   - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
//   - localparams W_DEF=64, CHUNK_DEF=16.
// - Sub-module cla_adder_chunk (CHUNK-bit combinational CLA: i_a, i_b, i_carry_in, o_s, o_carry_out), instantiated once.
// - Top level holds the FSM, chunk index counter ($clog2(NCHUNK) bits), operand/result shift-free registers (indexed slices) and carry flop.
// TESTING
// - Check outputs only when o_valid=1.
// - 0 - 0, borrow_in 0 -> d=0, borrow 0, zero 1, ovf 0; o_valid exactly 4 cycles after accept.
// - 0x99999999 - 0x87654321, borrow_in 0 -> d=0x12345678, borrow 0, ovf 0.
// - 0 - 1 -> d=0xFFFFFFFFFFFFFFFF, borrow 1, zero 0; carry ripples across all 4 chunks.
// - 0xFFFFFFFFFFFFFFFF - 0xFFFFFFFFFFFFFFFF, borrow_in 1 -> d=0xFFFFFFFFFFFFFFFF, borrow 1.
// - 0x8000000000000000 - 1 -> d=0x7FFFFFFFFFFFFFFF, ovf 1, borrow 0. Separately, 0x1111111111111100 - 0xFEDCBA9876543210 -> d=0x123456789ABCDEF0, borrow 1.
// - Handshake and reset:
//   - hold i_ready=0 for 3 cycles in DONE -> outputs stable, o_ready=0;
//   - i_valid during RUN is ignored;
//   - i_rst_n pulsed low mid-RUN -> o_valid stays 0, o_ready=1 immediately.

Source files
------------

// File: rtl/sub_64_seq_pkg.sv
// Shared types and defaults for the sequential 64-bit subtractor.
package sub_64_pkg;

  localparam int W_DEF     = 64;
  localparam int CHUNK_DEF = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

endpackage

// File: rtl/sub_64_seq_if.sv
// Operand/result handshake bundle for sub_64_seq.
interface sub_64_seq_if #(parameter int W = 64) ();
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_borrow_in;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_d;
  logic         o_borrow_out;
  logic         o_overflow;
  logic         o_zero;

  // Producer/consumer side driving operands and accepting results.
  modport master (
    output i_valid, i_a, i_b, i_borrow_in, i_ready,
    input  o_ready, o_valid, o_d, o_borrow_out, o_overflow, o_zero
  );

  // Subtractor side.
  modport slave (
    input  i_valid, i_a, i_b, i_borrow_in, i_ready,
    output o_ready, o_valid, o_d, o_borrow_out, o_overflow, o_zero
  );
endinterface

// File: rtl/sub_64_seq_cla_adder_chunk.sv
// CHUNK-bit combinational adder; carries resolved from generate/propagate terms.
module cla_adder_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_carry_in,
  output logic [CHUNK-1:0] o_s,
  output logic             o_carry_out
);

  logic [CHUNK-1:0] g, p;
  logic [CHUNK:0]   c;

  // c[i+1] = g[i] | p[i]&c[i], expanded by the loop into flat lookahead terms.
  function automatic logic [CHUNK:0] carries(input logic [CHUNK-1:0] gi,
                                             input logic [CHUNK-1:0] pi,
                                             input logic             cin);
    logic [CHUNK:0] cc;
    cc    = '0;
    cc[0] = cin;
    for (int i = 0; i < CHUNK; i++) cc[i+1] = gi[i] | (pi[i] & cc[i]);
    return cc;
  endfunction

  assign g           = i_a & i_b;
  assign p           = i_a ^ i_b;
  assign c           = carries(g, p, i_carry_in);
  assign o_s         = p ^ c[CHUNK-1:0];
  assign o_carry_out = c[CHUNK];

endmodule

// File: rtl/sub_64_seq.sv
// Multi-cycle subtractor D = A - B - borrow_in, one CHUNK slice per clock,
// computed as A + ~B + ~borrow_in through a single shared chunk adder.
module sub_64_seq
  import sub_64_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  sub_64_seq_if.slave  bus
);

  localparam int NCHUNK = W / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      nb_q, nb_d;     // inverted subtrahend
  logic [W-1:0]      res_q, res_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [CHUNK-1:0]  sl_a, sl_b, sl_s;
  logic              sl_co;
  logic              last_slice;

  assign sl_a       = a_q[idx_q*CHUNK +: CHUNK];
  assign sl_b       = nb_q[idx_q*CHUNK +: CHUNK];
  assign last_slice = (idx_q == IDXW'(NCHUNK - 1));

  cla_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a         (sl_a),
    .i_b         (sl_b),
    .i_carry_in  (carry_q),
    .o_s         (sl_s),
    .o_carry_out (sl_co)
  );

  // Next-state, operand capture, slice write-back and flag evaluation.
  // Sign bits come straight from the latched operands: a_q[W-1] and ~nb_q[W-1].
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    nb_d     = nb_q;
    res_d    = res_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_a;
          nb_d    = ~bus.i_b;
          carry_d = ~bus.i_borrow_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[idx_q*CHUNK +: CHUNK] = sl_s;
        carry_d = sl_co;
        idx_d   = idx_q + 1'b1;
        if (last_slice) begin
          idx_d    = '0;
          state_d  = S_DONE;
          borrow_d = ~sl_co;
          ovf_d    = (a_q[W-1] != ~nb_q[W-1]) & (sl_s[CHUNK-1] != a_q[W-1]);
          zero_d   = (res_d == '0);
        end
      end
      S_DONE: begin
        if (bus.i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; everything returns to a known value on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      nb_q     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.o_ready      = (state_q == S_IDLE);
  assign bus.o_valid      = (state_q == S_DONE);
  assign bus.o_d          = res_q;
  assign bus.o_borrow_out = borrow_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_zero       = zero_q;

endmodule

// File: tb/tb_sub_64_seq.sv
// Scoreboard bench for sub_64_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_sub_64_seq;

  typedef struct {
    logic [63:0] d;
    logic        b;
    logic        v;
    logic        z;
  } exp_t;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  exp_t sb[$];

  sub_64_seq_if #(.W(64)) bus ();

  sub_64_seq #(.W(64), .CHUNK(16)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Result monitor: one scoreboard entry per completed result handshake.
  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("d",      bus.o_d,               e.d);
        check("borrow", {63'd0, bus.o_borrow_out}, {63'd0, e.b});
        check("ovf",    {63'd0, bus.o_overflow},   {63'd0, e.v});
        check("zero",   {63'd0, bus.o_zero},       {63'd0, e.z});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("ready_wait", {63'd0, bus.o_ready}, 64'd1);
  endtask

  // Issue one op; verify latency, o_ready low while busy, optional RUN
  // noise on i_valid and optional 3-cycle backpressure in DONE.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                       input logic [63:0] d, input logic eb, input logic ev,
                       input logic ez, input bit noise, input bit hold);
    exp_t e;
    wait_ready();
    e.d = d; e.b = eb; e.v = ev; e.z = ez;
    if (hold) bus.i_ready = 1'b0;
    bus.i_a = a; bus.i_b = b; bus.i_borrow_in = bin; bus.i_valid = 1'b1;
    sb.push_back(e);
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    bus.i_a = ~a; bus.i_b = a; bus.i_borrow_in = ~bin;
    check("lat0_valid", {63'd0, bus.o_valid}, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      if (noise && k <= 2) begin
        bus.i_valid = 1'b1;
        bus.i_a = 64'h0123_4567_89AB_CDEF;
        bus.i_b = 64'h1;
      end else begin
        bus.i_valid = 1'b0;
      end
      @(posedge i_clk); #1;
      check("lat_valid", {63'd0, bus.o_valid}, (k == 4) ? 64'd1 : 64'd0);
      if (k < 4) check("busy_ready", {63'd0, bus.o_ready}, 64'd0);
    end
    bus.i_valid = 1'b0;
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        check("hold_valid", {63'd0, bus.o_valid}, 64'd1);
        check("hold_ready", {63'd0, bus.o_ready}, 64'd0);
        check("hold_d", bus.o_d, d);
        check("hold_borrow", {63'd0, bus.o_borrow_out}, {63'd0, eb});
        @(posedge i_clk); #1;
      end
      bus.i_ready = 1'b1;
    end
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_a = '0; bus.i_b = '0; bus.i_borrow_in = 1'b0;
    #2 i_rst_n = 1'b0;
    #2;
    check("rst_ready",  {63'd0, bus.o_ready},      64'd1);
    check("rst_valid",  {63'd0, bus.o_valid},      64'd0);
    check("rst_d",      bus.o_d,                   64'd0);
    check("rst_borrow", {63'd0, bus.o_borrow_out}, 64'd0);
    check("rst_ovf",    {63'd0, bus.o_overflow},   64'd0);
    check("rst_zero",   {63'd0, bus.o_zero},       64'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    //     a                       b                       bin   d                       b  v  z  noise hold
    do_op(64'h0,                  64'h0,                  1'b0, 64'h0,                  0, 0, 1, 0, 0);
    do_op(64'h99999999,           64'h87654321,           1'b0, 64'h12345678,           0, 0, 0, 0, 0);
    do_op(64'h0,                  64'h1,                  1'b0, 64'hFFFFFFFFFFFFFFFF,   1, 0, 0, 0, 0);
    do_op(64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   1'b1, 64'hFFFFFFFFFFFFFFFF,   1, 0, 0, 0, 0);
    do_op(64'h8000000000000000,   64'h1,                  1'b0, 64'h7FFFFFFFFFFFFFFF,   0, 1, 0, 0, 0);
    do_op(64'h1111111111111100,   64'hFEDCBA9876543210,   1'b0, 64'h123456789ABCDEF0,   1, 0, 0, 0, 0);
    do_op(64'h7FFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   1'b0, 64'h8000000000000000,   1, 1, 0, 0, 0);
    do_op(64'h5,                  64'h3,                  1'b1, 64'h1,                  0, 0, 0, 1, 0);
    do_op(64'h3,                  64'h3,                  1'b1, 64'hFFFFFFFFFFFFFFFF,   1, 0, 0, 0, 1);
    do_op(64'h4,                  64'h3,                  1'b1, 64'h0,                  0, 0, 1, 0, 0);

    // Reset pulse in the middle of RUN discards the op.
    wait_ready();
    bus.i_a = 64'h10; bus.i_b = 64'h1; bus.i_borrow_in = 1'b0; bus.i_valid = 1'b1;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    @(posedge i_clk); #1;
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_ready", {63'd0, bus.o_ready}, 64'd1);
    check("midrst_valid", {63'd0, bus.o_valid}, 64'd0);
    check("midrst_d",     bus.o_d,              64'd0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk); #1;
      check("postrst_valid", {63'd0, bus.o_valid}, 64'd0);
      check("postrst_ready", {63'd0, bus.o_ready}, 64'd1);
    end

    do_op(64'hDEADBEEF00000000,   64'h00000000DEADBEEF,   1'b0, 64'hDEADBEEE21524111,   0, 0, 0, 0, 0);

    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge i_clk);
    #1;
    check("drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
